// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame size, command bytes.
// Used by the host transmitter and the keyboard receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 pins plus clock falling-edge detect.
// Lines idle high, so the chain resets to 1 to avoid a spurious edge.
import ps2_pkg::*;

module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_lvl,
  output logic data_lvl,
  output logic clk_fall
);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], clk_pin};
      data_sync <= {data_sync[0], data_pin};
      clk_prev  <= clk_sync[1];
    end
  end

  assign clk_lvl  = clk_sync[1];
  assign data_lvl = data_sync[1];
  assign clk_fall = clk_prev & ~clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, ACK check.
// Optional watchdog on SEND/ACK/WAIT_IDLE enabled by PS2_TX_TIMEOUT_EN.
import ps2_pkg::*;

module ps2_host_tx #(
  parameter int INHIBIT_CYC = 12000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam logic [INH_W-1:0] INH_LAST =
    INH_W'(INHIBIT_CYC - 1);
  localparam logic [3:0] LAST_BIT =
    4'(PS2_FRAME_BITS - 2);

  ps2_state_e       state, state_n;
  logic [8:0]       shreg, shreg_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [INH_W-1:0] inh_cnt, inh_cnt_n;
  logic             clk_oe_n, data_oe_n;
  logic             done_n, err_n;
  logic             clk_lvl, data_lvl, clk_fall;
  logic             tmo_hit;

  ps2_sync_edge u_sync (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .clk_pin  (ps2_clk_in),
    .data_pin (ps2_data_in),
    .clk_lvl  (clk_lvl),
    .data_lvl (data_lvl),
    .clk_fall (clk_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_run;

  assign tmo_run = (state == ST_SEND) ||
                   (state == ST_ACK) ||
                   (state == ST_WAIT_IDLE);

  // Count from clock release; zero outside the watched states.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt <= '0;
    end else if (tmo_run) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = tmo_run && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      inh_cnt     <= inh_cnt_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      err         <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    inh_cnt_n = inh_cnt;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid) begin
          shreg_n   = {odd_parity(tx_data), tx_data};
          bit_cnt_n = '0;
          inh_cnt_n = '0;
          clk_oe_n  = 1'b1;
          state_n   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          data_oe_n = 1'b1;
          state_n   = ST_REQ;
        end else begin
          inh_cnt_n = inh_cnt + INH_W'(1);
        end
      end
      ST_REQ: begin
        clk_oe_n = 1'b0;
        state_n  = ST_SEND;
      end
      ST_SEND: begin
        if (tmo_hit) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          err_n     = 1'b1;
          state_n   = ST_IDLE;
        end else if (clk_fall) begin
          if (bit_cnt == LAST_BIT) begin
            data_oe_n = 1'b0;
            state_n   = ST_ACK;
          end else begin
            data_oe_n = ~shreg[0];
            shreg_n   = {1'b0, shreg[8:1]};
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      ST_ACK: begin
        // An ACK edge takes priority over a coincident timeout.
        if (clk_fall) begin
          done_n  = ~data_lvl;
          err_n   = data_lvl;
          state_n = ST_WAIT_IDLE;
        end else if (tmo_hit) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          err_n     = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (tmo_hit) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          err_n     = 1'b1;
          state_n   = ST_IDLE;
        end else if (clk_lvl && data_lvl) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = ST_IDLE;
      end
    endcase
  end

endmodule
